// File: rtl/ltc2315_sdo_emulator_if.sv
// Serial pins and sample-stream handshake between an LTC2315 initiator and the emulated ADC.
// The master side drives cs/sck and pushes sample words; the slave side answers on sdo.
interface ltc2315_sdo_emulator_if #(
  parameter int DATA_W = 12
);
  logic              cs;
  logic              sck;
  logic              sdo;
  logic              sdo_oe;
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output cs, sck, sample_in, sample_valid,
    input  sdo, sdo_oe, sample_ready
  );

  modport slave (
    input  cs, sck, sample_in, sample_valid,
    output sdo, sdo_oe, sample_ready
  );
endinterface

// File: rtl/ltc2315_sdo_emulator.sv
// LTC2315-12 stand-in: an SPI target that shifts one sample per cs-low frame onto sdo.
// Samples come from a one-deep external holding register, a free ramp, or a constant word.
module ltc2315_sdo_emulator #(
  parameter int                DATA_W      = 12,
  parameter int                LEAD_ZEROS  = 1,
  parameter logic [DATA_W-1:0] CONST_WORD  = {1'b1, {(DATA_W-1){1'b0}}},
  parameter int                SYNC_STAGES = 2
) (
  input  logic                         clk_100,
  input  logic                         reset,
  ltc2315_sdo_emulator_if.slave        bus,
  input  logic [1:0]                   mode,
  output logic                         frame_done,
  output logic                         short_frame,
  output logic                         underrun,
  output logic [15:0]                  frame_cnt
);

  localparam int LC_W = (LEAD_ZEROS > 1) ? $clog2(LEAD_ZEROS) : 1;
  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [LC_W-1:0] LEAD_LAST = LC_W'((LEAD_ZEROS > 0) ? LEAD_ZEROS - 1 : 0);
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_TAIL
  } state_t;

  // Pin synchronisers and edge detection
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic                   cs_q;
  logic                   sck_q;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   sck_fall;

  // These flops follow the pins even during reset, so a cs held low through
  // reset is already "old news" afterwards and cannot fake a falling edge.
  always_ff @(posedge clk_100) begin
    cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
    sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
    cs_q     <= cs_sync[SYNC_STAGES-1];
    sck_q    <= sck_sync[SYNC_STAGES-1];
  end

  assign cs_fall  =  cs_q  & ~cs_sync[SYNC_STAGES-1];
  assign cs_rise  = ~cs_q  &  cs_sync[SYNC_STAGES-1];
  assign sck_fall =  sck_q & ~sck_sync[SYNC_STAGES-1];

  // Frame state and datapath registers
  state_t            state,      state_nx;
  logic              sdo_r,      sdo_nx;
  logic              oe_r,       oe_nx;
  logic [DATA_W-1:0] shift_reg,  shift_nx;
  logic [LC_W-1:0]   lead_cnt,   lead_nx;
  logic [BC_W-1:0]   bit_cnt,    bit_nx;
  logic              ramp_frame, ramp_frame_nx;
  logic              start;
  logic              done_nx;
  logic              short_nx;

  // Holding register, ramp and history
  logic [DATA_W-1:0] hold_reg;
  logic              hold_full;
  logic [DATA_W-1:0] ramp;
  logic [DATA_W-1:0] last_word;
  logic              accept;
  logic              consume;

  // Word source, only acted upon in the cs-fall cycle
  logic [DATA_W-1:0] src_word;
  logic              src_consume;
  logic              src_underrun;

  always_comb begin
    src_word     = CONST_WORD;
    src_consume  = 1'b0;
    src_underrun = 1'b0;
    unique case (mode)
      2'd0: begin
        if (hold_full) begin
          src_word    = hold_reg;
          src_consume = 1'b1;
        end else begin
          src_word     = last_word;
          src_underrun = 1'b1;
        end
      end
      2'd1:    src_word = ramp;
      default: src_word = CONST_WORD;
    endcase
  end

  // NOTE: every variable assigned here gets its default first, so no path can infer a latch.
  always_comb begin
    state_nx      = state;
    sdo_nx        = sdo_r;
    oe_nx         = oe_r;
    shift_nx      = shift_reg;
    lead_nx       = lead_cnt;
    bit_nx        = bit_cnt;
    ramp_frame_nx = ramp_frame;
    start         = 1'b0;
    done_nx       = 1'b0;
    short_nx      = 1'b0;

    if (cs_rise) begin
      state_nx = ST_IDLE;
      sdo_nx   = 1'b0;
      oe_nx    = 1'b0;
      done_nx  = (state == ST_TAIL);
      short_nx = (state == ST_LEAD) || (state == ST_SHIFT);
    end else begin
      unique case (state)
        ST_IDLE: begin
          // An sck edge coinciding with the cs fall is deliberately not looked at.
          if (cs_fall) begin
            start         = 1'b1;
            oe_nx         = 1'b1;
            lead_nx       = '0;
            bit_nx        = '0;
            ramp_frame_nx = (mode == 2'd1);
            if (LEAD_ZEROS == 0) begin
              sdo_nx   = src_word[DATA_W-1];
              shift_nx = {src_word[DATA_W-2:0], 1'b0};
              state_nx = ST_SHIFT;
            end else begin
              sdo_nx   = 1'b0;
              shift_nx = src_word;
              state_nx = ST_LEAD;
            end
          end
        end
        ST_LEAD: begin
          if (sck_fall) begin
            if (lead_cnt == LEAD_LAST) begin
              sdo_nx   = shift_reg[DATA_W-1];
              shift_nx = {shift_reg[DATA_W-2:0], 1'b0};
              state_nx = ST_SHIFT;
            end else begin
              sdo_nx  = 1'b0;
              lead_nx = lead_cnt + 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          // The first data bit is already on sdo when SHIFT is entered, so the
          // last counted fall here moves sdo past D0 into the tail.
          if (sck_fall) begin
            if (bit_cnt == BIT_LAST) begin
              sdo_nx   = 1'b0;
              state_nx = ST_TAIL;
            end else begin
              sdo_nx   = shift_reg[DATA_W-1];
              shift_nx = {shift_reg[DATA_W-2:0], 1'b0};
              bit_nx   = bit_cnt + 1'b1;
            end
          end
        end
        ST_TAIL: begin
          if (sck_fall) sdo_nx = 1'b0;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk_100) begin
    if (reset) begin
      state      <= ST_IDLE;
      sdo_r      <= 1'b0;
      oe_r       <= 1'b0;
      shift_reg  <= '0;
      lead_cnt   <= '0;
      bit_cnt    <= '0;
      ramp_frame <= 1'b0;
    end else begin
      state      <= state_nx;
      sdo_r      <= sdo_nx;
      oe_r       <= oe_nx;
      shift_reg  <= shift_nx;
      lead_cnt   <= lead_nx;
      bit_cnt    <= bit_nx;
      ramp_frame <= ramp_frame_nx;
    end
  end

  assign accept  = bus.sample_valid & ~hold_full;
  assign consume = start & src_consume;

  always_ff @(posedge clk_100) begin
    if (reset) begin
      hold_full   <= 1'b0;
      last_word   <= '0;
      ramp        <= '0;
      frame_cnt   <= '0;
      frame_done  <= 1'b0;
      short_frame <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      hold_full   <= (hold_full & ~consume) | accept;
      frame_done  <= done_nx;
      short_frame <= short_nx;
      underrun    <= start & src_underrun;
      if (consume)                last_word <= hold_reg;
      if (done_nx)                frame_cnt <= frame_cnt + 16'd1;
      if (done_nx && ramp_frame)  ramp      <= ramp + 1'b1;
    end
  end

  // NOTE: the holding word needs no reset; hold_full alone says whether it means anything.
  always_ff @(posedge clk_100) begin
    if (accept) hold_reg <= bus.sample_in;
  end

  assign bus.sdo          = sdo_r;
  assign bus.sdo_oe       = oe_r;
  assign bus.sample_ready = ~hold_full;

endmodule

// File: tb/tb_ltc2315_sdo_emulator.sv
// Directed bench for the LTC2315 sdo emulator: a frame-level model predicts each bit on sdo,
// the pulses and the frame counter; a monitor compares sdo/sdo_oe on every settled cycle.
module tb_ltc2315_sdo_emulator;

  localparam int DATA_W     = 12;
  localparam int LEAD_ZEROS = 1;
  localparam int FRAME_BITS = LEAD_ZEROS + DATA_W;
  localparam logic [DATA_W-1:0] CONST_WORD = 12'h800;

  logic        clk_100 = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        frame_done;
  logic        short_frame;
  logic        underrun;
  logic [15:0] frame_cnt;

  always #5 clk_100 = ~clk_100;

  ltc2315_sdo_emulator_if #(.DATA_W(DATA_W)) bus ();

  ltc2315_sdo_emulator #(
    .DATA_W      (DATA_W),
    .LEAD_ZEROS  (LEAD_ZEROS),
    .CONST_WORD  (CONST_WORD),
    .SYNC_STAGES (2)
  ) dut (
    .clk_100     (clk_100),
    .reset       (reset),
    .bus         (bus),
    .mode        (mode),
    .frame_done  (frame_done),
    .short_frame (short_frame),
    .underrun    (underrun),
    .frame_cnt   (frame_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Frame-level model of the emulator
  int              m_frame_cnt;
  logic [DATA_W-1:0] m_ramp;
  logic [DATA_W-1:0] m_last_word;
  logic [DATA_W-1:0] m_hold_word;
  bit              m_hold_full;

  function automatic void model_reset();
    m_frame_cnt = 0;
    m_ramp      = '0;
    m_last_word = '0;
    m_hold_word = '0;
    m_hold_full = 0;
  endfunction

  // Value on sdo after k detected sck falls in a frame carrying word w.
  function automatic logic frame_bit(input logic [DATA_W-1:0] w, input int k);
    if (k < LEAD_ZEROS)  return 1'b0;
    if (k < FRAME_BITS)  return w[DATA_W-1-(k-LEAD_ZEROS)];
    return 1'b0;
  endfunction

  // Per-cycle compare and pulse counting
  logic mon_en  = 1'b0;
  logic exp_sdo = 1'b0;
  int   cnt_done, cnt_short, cnt_under;

  always @(negedge clk_100) begin
    if (frame_done)  cnt_done++;
    if (short_frame) cnt_short++;
    if (underrun)    cnt_under++;
    if (mon_en) begin
      check("sdo_oe in frame", 32'(bus.sdo_oe), 32'd1);
      check("sdo bit",         32'(bus.sdo),    32'(exp_sdo));
    end
  end

  initial begin
    #1ms;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    check("sample_ready before push", 32'(bus.sample_ready), 32'(!m_hold_full));
    bus.sample_valid = 1'b1;
    bus.sample_in    = w;
    tick(1);
    bus.sample_valid = 1'b0;
    if (!m_hold_full) begin
      m_hold_full = 1;
      m_hold_word = w;
    end
  endtask

  // One cs-low frame with n_sck clocks (half period 4 clk_100); cap holds the first 16 sdo samples.
  task automatic run_frame(input logic [1:0] m, input int n_sck, input bit push_at_fall,
                           input logic [DATA_W-1:0] push_word, output logic [15:0] cap);
    logic [DATA_W-1:0] w;
    bit exp_under;
    bit hold_before;
    exp_under   = 0;
    hold_before = m_hold_full;
    case (m)
      2'd0: begin
        if (m_hold_full) begin
          w           = m_hold_word;
          m_hold_full = 0;
          m_last_word = w;
        end else begin
          w         = m_last_word;
          exp_under = 1;
        end
      end
      2'd1:    w = m_ramp;
      default: w = CONST_WORD;
    endcase
    if (push_at_fall && !hold_before) begin
      m_hold_full = 1;
      m_hold_word = push_word;
    end

    cnt_done = 0; cnt_short = 0; cnt_under = 0;
    cap  = '0;
    mode = m;
    bus.cs = 1'b0;
    if (push_at_fall) begin
      tick(2);
      bus.sample_valid = 1'b1;
      bus.sample_in    = push_word;
      tick(1);
      bus.sample_valid = 1'b0;
      tick(2);
    end else begin
      tick(5);
    end
    mode    = m ^ 2'b01;
    exp_sdo = frame_bit(w, 0);
    mon_en  = 1'b1;
    cap     = {cap[14:0], bus.sdo};
    for (int k = 1; k <= n_sck; k++) begin
      tick(4);
      mon_en  = 1'b0;
      bus.sck = 1'b0;
      tick(4);
      exp_sdo = frame_bit(w, k);
      mon_en  = 1'b1;
      if (k < 16) cap = {cap[14:0], bus.sdo};
      bus.sck = 1'b1;
    end
    tick(4);
    mon_en = 1'b0;
    bus.cs = 1'b1;
    tick(6);

    if (n_sck >= FRAME_BITS) begin
      m_frame_cnt = (m_frame_cnt + 1) % 65536;
      if (m == 2'd1) m_ramp = m_ramp + 1'b1;
    end
    check("frame_done pulses",  32'(cnt_done),  32'(n_sck >= FRAME_BITS));
    check("short_frame pulses", 32'(cnt_short), 32'(n_sck <  FRAME_BITS));
    check("underrun pulses",    32'(cnt_under), 32'(exp_under));
    check("frame_cnt",          32'(frame_cnt), 32'(m_frame_cnt));
    check("sdo_oe after frame", 32'(bus.sdo_oe), 32'd0);
    check("sdo after frame",    32'(bus.sdo),    32'd0);
    check("sample_ready after frame", 32'(bus.sample_ready), 32'(!m_hold_full));
  endtask

  logic [15:0] cap;

  initial begin
    model_reset();
    reset            = 1'b1;
    bus.cs           = 1'b1;
    bus.sck          = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    mode             = 2'd0;
    tick(5);
    check("reset sdo",          32'(bus.sdo),          32'd0);
    check("reset sdo_oe",       32'(bus.sdo_oe),       32'd0);
    check("reset sample_ready", 32'(bus.sample_ready), 32'd1);
    check("reset frame_cnt",    32'(frame_cnt),        32'd0);
    check("reset pulses",       32'({frame_done, short_frame, underrun}), 32'd0);
    reset = 1'b0;
    tick(4);

    // External word A5C, 16 clocks
    push(12'hA5C);
    check("sample_ready after push", 32'(bus.sample_ready), 32'd0);
    run_frame(2'd0, 16, 0, '0, cap);
    check("A5C sdo sequence", 32'(cap), 32'h52E0);
    check("frame_cnt after A5C", 32'(frame_cnt), 32'd1);

    // Ramp from reset
    for (int i = 0; i < 3; i++) begin
      run_frame(2'd1, 16, 0, '0, cap);
      check("ramp word", 32'(cap[14:3]), 32'(i));
    end

    // Short frame leaves ramp alone; next frame resends the same value
    run_frame(2'd1, 6, 0, '0, cap);
    run_frame(2'd1, 16, 0, '0, cap);
    check("ramp resend after short", 32'(cap[14:3]), 32'h003);

    // Constant modes and the frame-length boundary
    run_frame(2'd2, 16, 0, '0, cap);
    check("mode2 word", 32'(cap[14:3]), 32'h800);
    run_frame(2'd3, 16, 0, '0, cap);
    check("mode3 word", 32'(cap[14:3]), 32'h800);
    run_frame(2'd2, FRAME_BITS, 0, '0, cap);
    run_frame(2'd2, FRAME_BITS - 1, 0, '0, cap);

    // Underrun resends last word; a push in the cs-fall cycle is kept for the next frame
    run_frame(2'd0, 16, 1, 12'h3C7, cap);
    check("underrun resends last_word", 32'(cap[14:3]), 32'hA5C);
    run_frame(2'd0, 16, 0, '0, cap);
    check("word pushed at cs fall", 32'(cap[14:3]), 32'h3C7);

    // A push while full is dropped
    push(12'h111);
    push(12'h222);
    run_frame(2'd0, 16, 0, '0, cap);
    check("push while full dropped", 32'(cap[14:3]), 32'h111);

    // Reset in the middle of a frame
    mode   = 2'd1;
    bus.cs = 1'b0;
    tick(5);
    for (int k = 0; k < 5; k++) begin
      bus.sck = 1'b0;
      tick(4);
      bus.sck = 1'b1;
      tick(4);
    end
    reset = 1'b1;
    tick(1);
    model_reset();
    check("mid-frame reset sdo_oe",    32'(bus.sdo_oe),       32'd0);
    check("mid-frame reset sdo",       32'(bus.sdo),          32'd0);
    check("mid-frame reset frame_cnt", 32'(frame_cnt),        32'd0);
    check("mid-frame reset ready",     32'(bus.sample_ready), 32'd1);
    tick(2);
    reset = 1'b0;
    cnt_done = 0; cnt_short = 0;
    tick(8);
    check("no frame without fresh cs fall", 32'(bus.sdo_oe), 32'd0);
    bus.cs = 1'b1;
    tick(6);
    check("cs rise in idle no pulse", 32'(cnt_done + cnt_short), 32'd0);
    run_frame(2'd1, 16, 0, '0, cap);
    check("clean frame after reset", 32'(cap[14:3]), 32'h000);
    check("frame_cnt after reset frame", 32'(frame_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
